// File: rtl/bitonic_pkg.sv
// Elaboration-time helpers describing the bitonic network geometry:
// stage count, pipeline depth, and per-column pair distance and direction.
package bitonic_pkg;

    function automatic int bitonic_stages(input int n);
        int s;
        s = 0;
        while ((1 << s) < n) s++;
        return s;
    endfunction

    function automatic int bitonic_latency(input int n);
        int s;
        s = bitonic_stages(n);
        return s * (s + 1) / 2;
    endfunction

    // Columns are numbered stage-major, substage counting down within a stage.
    function automatic int col_stage(input int col, input int n);
        int c;
        int r;
        c = 0;
        r = 0;
        for (int s = 0; s < bitonic_stages(n); s++) begin
            for (int t = s; t >= 0; t--) begin
                if (c == col) r = s;
                c++;
            end
        end
        return r;
    endfunction

    function automatic int col_dist(input int col, input int n);
        int c;
        int r;
        c = 0;
        r = 1;
        for (int s = 0; s < bitonic_stages(n); s++) begin
            for (int t = s; t >= 0; t--) begin
                if (c == col) r = 1 << t;
                c++;
            end
        end
        return r;
    endfunction

    function automatic bit col_asc(input int col, input int i, input int n);
        int s;
        s = col_stage(col, n);
        if (s == bitonic_stages(n) - 1) return 1'b1;
        return ((i >> (s + 1)) & 1) == 0;
    endfunction

endpackage

// File: rtl/bitonic_cmp_swap.sv
// Combinational compare-exchange on the key field; payload bits travel with the key.
// With asc = 1 the smaller key leaves on lo; equal keys never swap.
module bitonic_cmp_swap #(
    parameter int DATA_WIDTH = 8,
    parameter int KEY_WIDTH  = DATA_WIDTH,
    parameter int SIGNED     = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  asc,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);
    logic [KEY_WIDTH-1:0] key_a;
    logic [KEY_WIDTH-1:0] key_b;
    logic                 a_gt_b;
    logic                 b_gt_a;
    logic                 swap;

    assign key_a = a[DATA_WIDTH-1 -: KEY_WIDTH];
    assign key_b = b[DATA_WIDTH-1 -: KEY_WIDTH];

    if (SIGNED != 0) begin : g_signed
        assign a_gt_b = $signed(key_a) > $signed(key_b);
        assign b_gt_a = $signed(key_b) > $signed(key_a);
    end else begin : g_unsigned
        assign a_gt_b = key_a > key_b;
        assign b_gt_a = key_b > key_a;
    end

    assign swap = asc ? a_gt_b : b_gt_a;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Streaming bitonic sorter: one registered compare-exchange column per layer,
// per-vector ascending/descending order, valid/ready flow with bubble collapse.
module bitonic_sort_pipe
    import bitonic_pkg::*;
#(
    parameter int NUM_INPUT  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int KEY_WIDTH  = DATA_WIDTH,
    parameter int SIGNED     = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] data_in,
    input  logic                            desc_in,
    input  logic                            valid,
    output logic                            ready,
    output logic [NUM_INPUT*DATA_WIDTH-1:0] data_out,
    output logic                            desc_out,
    output logic                            done,
    input  logic                            out_ready
);
    localparam int VW = NUM_INPUT * DATA_WIDTH;
    localparam int L  = bitonic_latency(NUM_INPUT);

    logic [VW-1:0] data_q  [L];
    logic [VW-1:0] col_in  [L];
    logic [VW-1:0] col_out [L];
    logic [L-1:0]  v_q;
    logic [L-1:0]  desc_q;
    logic [L-1:0]  v_in;
    logic [L-1:0]  desc_col;
    logic [L:0]    adv;

    // NOTE: the whole stall chain lives in one process using blocking
    // assignments, so each adv[k] sees the freshly computed adv[k+1].
    always_comb begin
        adv    = '0;
        adv[L] = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    always_comb begin
        v_in     = '0;
        desc_col = '0;
        for (int k = 0; k < L; k++) begin
            if (k == 0) begin
                col_in[k]   = data_in;
                v_in[k]     = valid;
                desc_col[k] = desc_in;
            end else begin
                col_in[k]   = data_q[k-1];
                v_in[k]     = v_q[k-1];
                desc_col[k] = desc_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_col
        localparam int D = col_dist(k, NUM_INPUT);
        for (genvar i = 0; i < NUM_INPUT; i++) begin : g_pair
            if ((i & D) == 0) begin : g_cmp
                localparam bit ASC = col_asc(k, i, NUM_INPUT);
                // The vector's own desc bit flips every local direction in this column.
                bitonic_cmp_swap #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .KEY_WIDTH  (KEY_WIDTH),
                    .SIGNED     (SIGNED)
                ) u_cmp (
                    .a   (col_in[k][i*DATA_WIDTH +: DATA_WIDTH]),
                    .b   (col_in[k][(i+D)*DATA_WIDTH +: DATA_WIDTH]),
                    .asc (ASC ^ desc_col[k]),
                    .lo  (col_out[k][i*DATA_WIDTH +: DATA_WIDTH]),
                    .hi  (col_out[k][(i+D)*DATA_WIDTH +: DATA_WIDTH])
                );
            end
        end
    end

    // NOTE: the data registers are reset too, because data_out must read zero
    // after reset rather than whatever was left in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            desc_q <= '0;
            for (int k = 0; k < L; k++) data_q[k] <= '0;
        end else begin
            for (int k = 0; k < L; k++) begin
                if (adv[k]) begin
                    v_q[k]    <= v_in[k];
                    desc_q[k] <= desc_col[k];
                    data_q[k] <= col_out[k];
                end
            end
        end
    end

    assign ready    = adv[0];
    assign done     = v_q[L-1];
    assign desc_out = desc_q[L-1];
    assign data_out = data_q[L-1];

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Directed bench for bitonic_sort_pipe: an 8x8 unsigned instance and a 2x8
// signed instance with a 4-bit key, checked against hand values and a reference sort.
module tb_bitonic_sort_pipe;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] data_in = '0;
    logic        desc_in = 1'b0;
    logic        valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        ready;
    logic [63:0] data_out;
    logic        desc_out;
    logic        done;

    logic [15:0] s_data_in = '0;
    logic        s_desc_in = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_out_ready = 1'b1;
    logic        s_ready;
    logic [15:0] s_data_out;
    logic        s_desc_out;
    logic        s_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bitonic_sort_pipe #(.NUM_INPUT(8), .DATA_WIDTH(8), .KEY_WIDTH(8), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .desc_in(desc_in), .valid(valid),
        .ready(ready), .data_out(data_out), .desc_out(desc_out), .done(done),
        .out_ready(out_ready)
    );

    bitonic_sort_pipe #(.NUM_INPUT(2), .DATA_WIDTH(8), .KEY_WIDTH(4), .SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .data_in(s_data_in), .desc_in(s_desc_in), .valid(s_valid),
        .ready(s_ready), .data_out(s_data_out), .desc_out(s_desc_out), .done(s_done),
        .out_ready(s_out_ready)
    );

    function automatic logic [63:0] gen_vec(input int j);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'((j * 53 + i * 29 + i * i * j + 7) % 256);
        return v;
    endfunction

    function automatic logic [63:0] ref_sort(input logic [63:0] v, input logic desc);
        logic [7:0]  e [8];
        logic [7:0]  tmp;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) e[i] = v[i*8 +: 8];
        for (int a = 0; a < 7; a++) begin
            for (int b = 0; b < 7 - a; b++) begin
                if (desc ? (e[b] < e[b+1]) : (e[b] > e[b+1])) begin
                    tmp = e[b]; e[b] = e[b+1]; e[b+1] = tmp;
                end
            end
        end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = e[i];
        return r;
    endfunction

    task automatic run_single(input logic [63:0] d, input logic ds,
                              output int lat, output logic [63:0] q, output logic qd);
        @(posedge clk); #1;
        data_in = d; desc_in = ds; valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; data_in = '0;
        lat = -1; q = '0; qd = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c; q = data_out; qd = desc_out;
                break;
            end
        end
    endtask

    task automatic run_small(input logic [15:0] d, input logic ds,
                             output int lat, output logic [15:0] q);
        @(posedge clk); #1;
        s_data_in = d; s_desc_in = ds; s_valid = 1'b1; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_data_in = '0;
        lat = -1; q = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (s_done) begin
                lat = c; q = s_data_out;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (data_out !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
        total++; if (desc_out !== 1'b0) begin bad++; $display("FAIL reset_desc got=%b want=0", desc_out); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (s_done !== 1'b0) begin bad++; $display("FAIL reset_s_done got=%b want=0", s_done); end
    endtask

    task automatic test_ascending;
        int lat; logic [63:0] q; logic qd;
        run_single(64'h01_04_02_06_00_07_03_05, 1'b0, lat, q, qd);
        total++; if (lat != LAT) begin bad++; $display("FAIL asc_latency got=%0d want=%0d", lat, LAT); end
        total++; if (q !== 64'h07_06_05_04_03_02_01_00) begin bad++; $display("FAIL asc_data got=%h want=%h", q, 64'h07_06_05_04_03_02_01_00); end
        total++; if (qd !== 1'b0) begin bad++; $display("FAIL asc_desc got=%b want=0", qd); end
    endtask

    task automatic test_descending;
        int lat; logic [63:0] q; logic qd;
        run_single(64'h01_04_02_06_00_07_03_05, 1'b1, lat, q, qd);
        total++; if (lat != LAT) begin bad++; $display("FAIL desc_latency got=%0d want=%0d", lat, LAT); end
        total++; if (q !== 64'h00_01_02_03_04_05_06_07) begin bad++; $display("FAIL desc_data got=%h want=%h", q, 64'h00_01_02_03_04_05_06_07); end
        total++; if (qd !== 1'b1) begin bad++; $display("FAIL desc_desc got=%b want=1", qd); end
    endtask

    task automatic test_signed_key;
        logic [15:0] vin  [3] = '{16'h12F1, 16'hF112, 16'h12F1};
        logic        dsc  [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] vexp [3] = '{16'h12F1, 16'h12F1, 16'hF112};
        int lat; logic [15:0] q;
        for (int c = 0; c < 3; c++) begin
            run_small(vin[c], dsc[c], lat, q);
            total++; if (lat != 1) begin bad++; $display("FAIL signed_latency[%0d] got=%0d want=1", c, lat); end
            total++; if (q !== vexp[c]) begin bad++; $display("FAIL signed_data[%0d] got=%h want=%h", c, q, vexp[c]); end
        end
    endtask

    task automatic test_equal_keys;
        logic [15:0] vin [3] = '{16'h3231, 16'h3132, 16'h3231};
        logic        dsc [3] = '{1'b0, 1'b0, 1'b1};
        int lat; logic [15:0] q;
        for (int c = 0; c < 3; c++) begin
            run_small(vin[c], dsc[c], lat, q);
            total++; if (q !== vin[c]) begin bad++; $display("FAIL equal_keys[%0d] got=%h want=%h", c, q, vin[c]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_q [20];
        logic        exp_d [20];
        int sent = 0, rcv = 0, first = -1, last = -1;
        for (int j = 0; j < 20; j++) begin
            exp_d[j] = 1'(j % 2);
            exp_q[j] = ref_sort(gen_vec(j), exp_d[j]);
        end
        for (int cyc = 0; cyc < 60 && rcv < 20; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            valid = (sent < 20);
            data_in = gen_vec(sent); desc_in = 1'(sent % 2);
            @(negedge clk);
            if (done) begin
                total++;
                if (data_out !== exp_q[rcv] || desc_out !== exp_d[rcv]) begin
                    bad++;
                    $display("FAIL b2b_out[%0d] got=%h/%b want=%h/%b", rcv, data_out, desc_out, exp_q[rcv], exp_d[rcv]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            if (valid && ready) sent++;
        end
        @(posedge clk); #1; valid = 1'b0;
        total++; if (rcv != 20) begin bad++; $display("FAIL b2b_count got=%0d want=20", rcv); end
        total++; if (last - first != 19) begin bad++; $display("FAIL b2b_contiguous span got=%0d want=19", last - first); end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp_q [16];
        logic [63:0] held_data = '0;
        logic        held_desc = 1'b0, held = 1'b0, in_x, out_x;
        int sent = 0, rcv = 0, occ = 0, max_occ = 0;
        for (int j = 0; j < 16; j++) exp_q[j] = ref_sort(gen_vec(50 + j), 1'(j % 2));
        for (int cyc = 0; cyc < 100 && rcv < 16; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc < 13);
            valid = (sent < 16);
            data_in = gen_vec(50 + sent); desc_in = 1'(sent % 2);
            @(negedge clk);
            total++;
            if (ready !== (out_ready ? 1'b1 : (occ != LAT))) begin
                bad++; $display("FAIL bp_ready cyc=%0d got=%b occ=%0d out_ready=%b", cyc, ready, occ, out_ready);
            end
            if (held) begin
                total++;
                if (done !== 1'b1 || data_out !== held_data || desc_out !== held_desc) begin
                    bad++; $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/%h", cyc, done, data_out, held_data);
                end
            end
            in_x = valid && ready;
            out_x = done && out_ready;
            if (out_x) begin
                total++;
                if (data_out !== exp_q[rcv] || desc_out !== 1'(rcv % 2)) begin
                    bad++; $display("FAIL bp_out[%0d] got=%h want=%h", rcv, data_out, exp_q[rcv]);
                end
                rcv++;
            end
            held = done && !out_ready;
            held_data = data_out; held_desc = desc_out;
            occ = occ + int'(in_x) - int'(out_x);
            if (occ > max_occ) max_occ = occ;
            if (in_x) sent++;
        end
        @(posedge clk); #1; valid = 1'b0; out_ready = 1'b1;
        total++; if (rcv != 16) begin bad++; $display("FAIL bp_count got=%0d want=16", rcv); end
        total++; if (max_occ != LAT) begin bad++; $display("FAIL bp_max_occupancy got=%0d want=%0d", max_occ, LAT); end
    endtask

    task automatic test_reset_midstream;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            reset = (cyc == 3);
            valid = (cyc <= 3);
            data_in = gen_vec(200 + cyc); desc_in = 1'b0;
            @(negedge clk);
            if (cyc == 4) begin
                total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", ready); end
                total++; if (data_out !== 64'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", data_out); end
            end
            if (cyc >= 4) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done cyc=%0d got=%b want=0", cyc, done); end
            end
        end
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_signed_key();
        test_equal_keys();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
